// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC -> req/ack instruction memory -> valid/ready slot to decode.
// Optional misaligned-PC trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        redirect,
  output logic        fetch_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_misalign
);

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t state, state_nxt;
  logic   slot_free;
  logic   misaligned;
  logic   trap_block;
  logic   issue;
  logic   load;
  logic   trap_load;
  logic   req_clr;

  assign slot_free = !instr_valid || instr_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trapped;

  assign misaligned = (pc[1:0] != 2'b00);
  assign trap_block = trapped;

  // Once a misalign marker is produced, nothing is fetched until the PC is redirected.
  always_ff @(posedge clk) begin
    if (rst)
      trapped <= 1'b0;
    else if (redirect)
      trapped <= 1'b0;
    else if (trap_load)
      trapped <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      instr_misalign <= 1'b0;
    else if (!redirect && load)
      instr_misalign <= 1'b0;
    else if (!redirect && trap_load)
      instr_misalign <= 1'b1;
  end
`else
  assign misaligned     = 1'b0;
  assign trap_block     = 1'b0;
  assign instr_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (issue) state_nxt = REQ;
      REQ: begin
        if (imem_ack)
          state_nxt = IDLE;
        else if (redirect)
          state_nxt = DROP;
      end
      DROP: if (imem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue     = 1'b0;
    trap_load = 1'b0;
    load      = 1'b0;
    req_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (slot_free && !redirect && !trap_block) begin
          if (misaligned)
            trap_load = 1'b1;
          else
            issue = 1'b1;
        end
      end
      REQ: begin
        if (imem_ack) begin
          req_clr = 1'b1;
          load    = !redirect;
        end
      end
      DROP: if (imem_ack) req_clr = 1'b1;
      default: ;
    endcase
    fetch_stall = !load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr       <= RESET_INSTR;
      instr_pc    <= '0;
    end else begin
      if (issue) begin
        imem_req  <= 1'b1;
        imem_addr <= pc & ADDR_MASK;
      end else if (req_clr) begin
        imem_req <= 1'b0;
      end

      // Redirect flushes the slot even if decode accepts it this same cycle.
      if (redirect) begin
        instr_valid <= 1'b0;
      end else if (load) begin
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        instr_pc    <= imem_addr;
      end else if (trap_load) begin
        instr_valid <= 1'b1;
        instr       <= RESET_INSTR;
        instr_pc    <= pc;
      end else if (instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
